imuldiv_int_div_var_latency: RTL and testbench

Parametrised iterative integer divider: the next-generation replacement for the fixed-width 32-bit iterative divide unit in the imuldiv block. It accepts signed/unsigned `W`-bit div/rem requests over val/rdy and returns `{remainder, quotient}` over val/rdy. It adds three behaviours:
- data-dependent latency, by skipping the dividend's leading zeros;
- defined divide-by-zero results;
- a one-cycle fast path for zero dividend or zero divisor.

---
 rtl/imuldiv_int_div_var_latency_pkg.sv | 37 +++
 rtl/imuldiv_int_div_var_latency_lzc.sv | 27 ++
 rtl/imuldiv_int_div_var_latency.sv | 150 +++++++++++++++
 tb/tb_imuldiv_int_div_var_latency.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_int_div_var_latency_pkg.sv
// Shared definitions for the variable-latency iterative divider: fn codes,
// request message layout (fn|a|b, 2W+1 bits), response layout {rem, quot}
// and control states.
package imuldiv_int_div_var_latency_pkg;

  localparam logic DIV_FN_UNSIGNED = 1'b0;
  localparam logic DIV_FN_SIGNED   = 1'b1;

  // Request message: [2W] = fn, [2W-1:W] = a, [W-1:0] = b
  function automatic int div_req_msg_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int div_req_fn_pos(input int w);
    return 2 * w;
  endfunction

  function automatic int div_req_a_lsb(input int w);
    return w;
  endfunction

  localparam int DIV_REQ_B_LSB = 0;

  // Response message: [2W-1:W] = remainder, [W-1:0] = quotient
  function automatic int div_resp_rem_lsb(input int w);
    return w;
  endfunction

  localparam int DIV_RESP_QUOT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/imuldiv_int_div_var_latency_lzc.sv
// Leading-zero counter for a W-bit word; returns W for an all-zero input.
// Latency: combinational.
// Backpressure: none (pure function of in_dat).
// Ports: in_dat [W-1:0] word to scan, lz_cnt [$clog2(W+1)-1:0] zeros above the first set bit.
module imuldiv_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]             in_dat,
  output logic [$clog2(W+1)-1:0]   lz_cnt
);

  localparam int CW = $clog2(W + 1);

  logic found;

  always_comb begin
    lz_cnt = CW'(W);
    found  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && in_dat[i]) begin
        lz_cnt = CW'(W - 1 - i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imuldiv_int_div_var_latency.sv
// Iterative restoring signed/unsigned W-bit divider returning {rem, quot}.
// Latency: n+1 cycles accept-to-valid, n = W - lz(|a|) (or W), n = 0 when a or b is zero.
// Backpressure: divreq_rdy only in IDLE; DONE holds result until divresp_rdy.
// Ports: clk/reset (sync, active-high); divreq_{msg_fn,msg_a,msg_b,val,rdy} request;
//        divresp_{msg_result,val,rdy} response with result = {rem, quot}.
module imuldiv_int_div_var_latency
  import imuldiv_int_div_var_latency_pkg::*;
#(
  parameter int W          = 32,
  parameter bit SKIP_ZEROS = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           divreq_msg_fn,
  input  logic [W-1:0]   divreq_msg_a,
  input  logic [W-1:0]   divreq_msg_b,
  input  logic           divreq_val,
  output logic           divreq_rdy,
  output logic [2*W-1:0] divresp_msg_result,
  output logic           divresp_val,
  input  logic           divresp_rdy
);

  localparam int CW    = $clog2(W + 1);
  localparam int MSG_W = div_req_msg_w(W);

  div_state_e   state_q, state_d;
  logic [W-1:0] dvd_q, dvd_d;        // dividend bits shift out the top, quotient bits in at the bottom
  logic [W:0]   rem_q, rem_d;
  logic [W-1:0] div_q, div_d;        // divisor magnitude
  logic [CW-1:0] cnt_q, cnt_d;       // iterations remaining
  logic         quot_neg_q, quot_neg_d;
  logic         rem_neg_q, rem_neg_d;

  logic [MSG_W-1:0] req_msg;
  logic             req_fn;
  logic [W-1:0]     req_a, req_b;
  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [CW-1:0]    lz_raw, lz_use;
  logic [W:0]       rem_shift;
  logic [W+1:0]     trial;
  logic             q_bit;
  logic [W-1:0]     quot_out, rem_out;

  assign req_msg = {divreq_msg_fn, divreq_msg_a, divreq_msg_b};
  assign req_fn  = req_msg[div_req_fn_pos(W)];
  assign req_a   = req_msg[div_req_a_lsb(W) +: W];
  assign req_b   = req_msg[DIV_REQ_B_LSB +: W];

  assign a_neg = (req_fn == DIV_FN_SIGNED) && req_a[W-1];
  assign b_neg = (req_fn == DIV_FN_SIGNED) && req_b[W-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;

  imuldiv_lzc #(.W(W)) u_lzc (
    .in_dat (a_mag),
    .lz_cnt (lz_raw)
  );

  // Pre-shifting by lz puts the first significant dividend bit at the top,
  // so the skipped iterations would only have shifted in zeros.
  assign lz_use = SKIP_ZEROS ? lz_raw : '0;

  // rem_q[W] is always 0 between iterations; keeping it in the trial
  // subtract makes the borrow land in bit W+1.
  assign rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
  assign trial     = {rem_q, dvd_q[W-1]} - {2'b00, div_q};
  assign q_bit     = ~trial[W+1];

  assign quot_out = quot_neg_q ? -dvd_q : dvd_q;
  assign rem_out  = rem_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];

  assign divresp_msg_result[div_resp_rem_lsb(W) +: W] = rem_out;
  assign divresp_msg_result[DIV_RESP_QUOT_LSB +: W]   = quot_out;

  assign divreq_rdy  = (state_q == ST_IDLE) && !reset;
  assign divresp_val = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (divreq_val && divreq_rdy) begin
          div_d      = b_mag;
          quot_neg_d = 1'b0;
          rem_neg_d  = 1'b0;
          if (req_b == '0) begin
            // Defined divide-by-zero: all-ones quotient, dividend as remainder
            dvd_d   = '1;
            rem_d   = {1'b0, req_a};
            state_d = ST_DONE;
          end else if (req_a == '0) begin
            dvd_d   = '0;
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            dvd_d      = a_mag << lz_use;
            rem_d      = '0;
            cnt_d      = CW'(W) - lz_use;
            quot_neg_d = (req_fn == DIV_FN_SIGNED) && (req_a[W-1] ^ req_b[W-1]);
            rem_neg_d  = a_neg;
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = q_bit ? trial[W:0] : rem_shift;
        dvd_d = {dvd_q[W-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (divresp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

endmodule

// File: tb/tb_imuldiv_int_div_var_latency.sv
module tb_imuldiv_int_div_var_latency;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           req_fn, req_val, resp_rdy;
  logic [W-1:0]   req_a, req_b;
  logic           req_rdy, resp_val;
  logic [2*W-1:0] resp_res;

  logic           h_fn, h_val, h_rdy, h_rsp_val, h_rsp_rdy;
  logic [15:0]    h_a, h_b;
  logic [31:0]    h_res;

  imuldiv_int_div_var_latency #(.W(W), .SKIP_ZEROS(1'b1)) dut (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (req_fn),
    .divreq_msg_a       (req_a),
    .divreq_msg_b       (req_b),
    .divreq_val         (req_val),
    .divreq_rdy         (req_rdy),
    .divresp_msg_result (resp_res),
    .divresp_val        (resp_val),
    .divresp_rdy        (resp_rdy)
  );

  imuldiv_int_div_var_latency #(.W(16), .SKIP_ZEROS(1'b0)) dut16 (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (h_fn),
    .divreq_msg_a       (h_a),
    .divreq_msg_b       (h_b),
    .divreq_val         (h_val),
    .divreq_rdy         (h_rdy),
    .divresp_msg_result (h_res),
    .divresp_val        (h_rsp_val),
    .divresp_rdy        (h_rsp_rdy)
  );

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    logic [2*W-1:0] res;
    int             due;
  } exp_t;
  exp_t sb[$];
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model, written from the arithmetic definition
  function automatic logic [2*W-1:0] model(input logic fn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sbv, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (!fn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
    sa  = $signed(a);
    sbv = $signed(b);
    q   = sa / sbv;
    r   = sa % sbv;
    return {r, q};
  endfunction

  function automatic int model_lat(input logic fn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int lz;
    if (a == '0 || b == '0) return 1;
    mag = (fn && a[W-1]) ? -a : a;
    lz = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
    return W - lz + 1;
  endfunction

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      seen = 1'b0;
    end else if (resp_val) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h expected no response", resp_res);
      end else begin
        if (!seen) begin
          check("latency", 64'(ncyc), 64'(sb[0].due));
          seen = 1'b1;
        end
        if (resp_rdy) begin
          check("result", resp_res, sb[0].res);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Response sink: 0 = always ready, 1 = stall, 2 = random
  int sink_mode = 0;
  initial begin
    resp_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       resp_rdy = 1'b1;
        1:       resp_rdy = 1'b0;
        default: resp_rdy = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic send(input logic fn, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp_res, input int lat);
    bit ok;
    @(posedge clk);
    #1;
    req_fn  = fn;
    req_a   = a;
    req_b   = b;
    req_val = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (req_rdy) ok = 1'b1;
    end
    if (ok) begin
      sb.push_back('{exp_res, ncyc + lat});
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got rdy=0 expected rdy=1");
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_val) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic run16(input logic fn, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_res, input int lat);
    bit ok;
    int c;
    @(posedge clk);
    #1;
    h_fn  = fn;
    h_a   = a;
    h_b   = b;
    h_val = 1'b1;
    ok = 1'b0;
    c  = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (h_rdy) begin
        ok = 1'b1;
        c  = ncyc;
      end
    end
    @(posedge clk);
    #1;
    h_val = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (h_rsp_val) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL w16_timeout: got no response expected response");
    end else begin
      check("w16_latency", 64'(ncyc - c), 64'(lat));
      check("w16_result", 64'(h_res), 64'(exp_res));
    end
  endtask

  typedef struct {
    logic           fn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    int             lat;
  } vec_t;
  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  vcnt;
    logic fn;
    logic [W-1:0] a, b;

    vt[0] = '{1'b1, 32'h0a01_b044, 32'hffff_b146, 64'h00000000_ffffdf76, 29};
    vt[1] = '{1'b0, 32'h8000_0001, 32'h8000_0000, 64'h00000001_00000001, 33};
    vt[2] = '{1'b0, 32'd5,         32'd7,         64'h00000005_00000000, 4};
    vt[3] = '{1'b1, 32'hffff_fff6, 32'h0,         64'hfffffff6_ffffffff, 1};
    vt[4] = '{1'b1, 32'h8000_0000, 32'hffff_ffff, 64'h00000000_80000000, 33};
    vt[5] = '{1'b0, 32'h0,         32'd9,         64'h00000000_00000000, 1};
    vt[6] = '{1'b0, 32'h1234_5678, 32'h0,         64'h12345678_ffffffff, 1};
    vt[7] = '{1'b1, 32'hffff_fff9, 32'd2,         64'hffffffff_fffffffd, 4};
    vt[8] = '{1'b0, 32'hffff_fff9, 32'd2,         64'h00000001_7ffffffc, 33};
    vt[9] = '{1'b1, 32'd100,       32'hffff_fff9, 64'h00000002_fffffff2, 8};

    reset     = 1'b1;
    req_val   = 1'b0;
    req_fn    = 1'b0;
    req_a     = '0;
    req_b     = '0;
    h_val     = 1'b0;
    h_fn      = 1'b0;
    h_a       = '0;
    h_b       = '0;
    h_rsp_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_resp_val", 64'(resp_val), 64'd0);
    check("rst_result", resp_res, 64'd0);
    check("rst_w16_result", 64'(h_res), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_rdy", 64'(req_rdy), 64'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      send(vt[i].fn, vt[i].a, vt[i].b, vt[i].res, vt[i].lat);
      wait_drain();
    end

    // Response backpressure with a second request waiting at the source
    sink_mode = 1;
    send(1'b0, 32'd1000, 32'd7, 64'h00000006_0000008e, 11);
    vcnt = 0;
    for (int t = 0; t < 100 && !resp_val; t++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      req_fn  = 1'b0;
      req_a   = 32'd77;
      req_b   = 32'd3;
      req_val = 1'b1;
      @(negedge clk);
      if (resp_val) vcnt++;
      check("bp_result_stable", resp_res, 64'h00000006_0000008e);
      check("bp_req_rdy", 64'(req_rdy), 64'd0);
    end
    check("bp_val_held", 64'(vcnt), 64'd10);
    @(posedge clk);
    #1;
    req_val   = 1'b0;
    sink_mode = 0;
    wait_drain();
    send(1'b0, 32'd77, 32'd3, 64'h00000002_00000019, 8);
    wait_drain();

    // Random source gaps and random sink stalls
    sink_mode = 2;
    for (int i = 0; i < 12; i++) begin
      fn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; b = '0; end
        1:       begin a = '0; b = $urandom; end
        2:       begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        default: begin a = $urandom; b = $urandom_range(1, 70000); end
      endcase
      if (b == '0 && i == 4) b = 32'd3;
      send(fn, a, b, model(fn, a, b), model_lat(fn, a, b));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain();
    sink_mode = 0;

    // Reset in the middle of a full-length divide
    send(1'b0, 32'h8000_0000, 32'd3, model(1'b0, 32'h8000_0000, 32'd3), 33);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_resp_val", 64'(resp_val), 64'd0);
    check("midrst_req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rdy_after", 64'(req_rdy), 64'd1);
    vcnt = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (resp_val) vcnt++;
    end
    check("midrst_no_resp", 64'(vcnt), 64'd0);
    send(1'b0, 32'd7, 32'd5, 64'h00000002_00000001, 4);
    wait_drain();

    // W = 16, fixed iteration count
    run16(1'b0, 16'hffff, 16'd2, 32'h0001_7fff, 17);
    run16(1'b1, 16'hff9c, 16'd4, 32'h0000_ffe7, 17);
    run16(1'b0, 16'h0000, 16'd5, 32'h0000_0000, 1);
    run16(1'b1, 16'h8000, 16'hffff, 32'h0000_8000, 17);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
